// File: rtl/pc_sequencer.sv
// Multi-cycle RV32I control sequencer: walks each instruction through
// fetch/decode/execute/memory/writeback and drives {reset,enable,pc_src,jalr} to the PC.
//
// state      | meaning
// RESET_HOLD | PC held in reset for RESET_HOLD_CYCLES edges after reset release
// FETCH      | imem request outstanding until imem_ready
// DECODE     | opcode class latched, unsupported/SYSTEM opcodes go to HALT
// EXECUTE    | branch decision registered
// MEMORY     | dmem request held until dmem_ready
// WRITEBACK  | PC update, register write, retire count
// HALT       | terminal, left only through reset
module pc_sequencer #(
    parameter int RESET_HOLD_CYCLES = 2,
    parameter int INSTRET_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic                     cmp_eq,
    input  logic                     cmp_lt,
    input  logic                     cmp_ltu,
    input  logic                     imem_ready,
    input  logic                     dmem_ready,
    input  logic                     halt_req,
    output logic [3:0]               pc_control,
    output logic                     imem_req,
    output logic                     ir_load,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic                     reg_write,
    output logic [2:0]               state,
    output logic [INSTRET_WIDTH-1:0] instret,
    output logic                     illegal
);

    localparam logic [2:0] S_RESET_HOLD = 3'd0;
    localparam logic [2:0] S_FETCH      = 3'd1;
    localparam logic [2:0] S_DECODE     = 3'd2;
    localparam logic [2:0] S_EXECUTE    = 3'd3;
    localparam logic [2:0] S_MEMORY     = 3'd4;
    localparam logic [2:0] S_WRITEBACK  = 3'd5;
    localparam logic [2:0] S_HALT       = 3'd6;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] C_NONE   = 4'd0;
    localparam logic [3:0] C_LUI    = 4'd1;
    localparam logic [3:0] C_AUIPC  = 4'd2;
    localparam logic [3:0] C_JAL    = 4'd3;
    localparam logic [3:0] C_JALR   = 4'd4;
    localparam logic [3:0] C_BRANCH = 4'd5;
    localparam logic [3:0] C_LOAD   = 4'd6;
    localparam logic [3:0] C_STORE  = 4'd7;
    localparam logic [3:0] C_OPIMM  = 4'd8;
    localparam logic [3:0] C_OP     = 4'd9;
    localparam logic [3:0] C_SYSTEM = 4'd10;

    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    logic [2:0]               r_state;
    logic [HOLD_W-1:0]        r_hold_cnt;
    logic [3:0]               r_op_class;
    logic                     r_take_branch;
    logic [INSTRET_WIDTH-1:0] r_instret;
    logic                     r_illegal;

    logic [3:0] w_dec_class;
    logic       w_branch_cond;
    logic       w_class_writes_rd;

    always_comb begin
        w_dec_class = C_NONE;
        case (opcode)
            OPC_LUI:    w_dec_class = C_LUI;
            OPC_AUIPC:  w_dec_class = C_AUIPC;
            OPC_JAL:    w_dec_class = C_JAL;
            OPC_JALR:   w_dec_class = C_JALR;
            OPC_BRANCH: w_dec_class = C_BRANCH;
            OPC_LOAD:   w_dec_class = C_LOAD;
            OPC_STORE:  w_dec_class = C_STORE;
            OPC_OPIMM:  w_dec_class = C_OPIMM;
            OPC_OP:     w_dec_class = C_OP;
            OPC_SYSTEM: w_dec_class = C_SYSTEM;
            default:    w_dec_class = C_NONE;
        endcase
    end

    // funct3 010/011 are not branch encodings and never take.
    always_comb begin
        w_branch_cond = 1'b0;
        case (funct3)
            3'b000:  w_branch_cond = cmp_eq;
            3'b001:  w_branch_cond = ~cmp_eq;
            3'b100:  w_branch_cond = cmp_lt;
            3'b101:  w_branch_cond = ~cmp_lt;
            3'b110:  w_branch_cond = cmp_ltu;
            3'b111:  w_branch_cond = ~cmp_ltu;
            default: w_branch_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_RESET_HOLD;
            r_hold_cnt    <= '0;
            r_op_class    <= C_NONE;
            r_take_branch <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            case (r_state)
                S_RESET_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_op_class <= w_dec_class;
                    if (w_dec_class == C_SYSTEM) begin
                        r_state <= S_HALT;
                    end else if (w_dec_class == C_NONE) begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    r_take_branch <= (r_op_class == C_BRANCH) && w_branch_cond;
                    if ((r_op_class == C_LOAD) || (r_op_class == C_STORE)) begin
                        r_state <= S_MEMORY;
                    end else begin
                        r_state <= S_WRITEBACK;
                    end
                end
                S_MEMORY: begin
                    if (dmem_ready) begin
                        r_state <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    r_state <= halt_req ? S_HALT : S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instret <= '0;
        end else if (r_state == S_WRITEBACK) begin
            r_instret <= r_instret + INSTRET_WIDTH'(1);
        end
    end

    always_comb begin
        case (r_op_class)
            C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_OP, C_OPIMM: w_class_writes_rd = 1'b1;
            default:                                              w_class_writes_rd = 1'b0;
        endcase
    end

    // Strobes come from registered state/flags only; ir_load also qualifies on imem_ready.
    always_comb begin
        pc_control = 4'b0000;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        case (r_state)
            S_RESET_HOLD: begin
                pc_control = 4'b1000;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = (r_op_class == C_STORE);
            end
            S_WRITEBACK: begin
                pc_control[3] = 1'b0;
                pc_control[2] = 1'b1;
                pc_control[1] = (r_op_class == C_JAL) ||
                                ((r_op_class == C_BRANCH) && r_take_branch);
                pc_control[0] = (r_op_class == C_JALR);
                reg_write     = w_class_writes_rd;
            end
            default: begin
                pc_control = 4'b0000;
            end
        endcase
    end

    assign state   = r_state;
    assign instret = r_instret;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected writeback responses,
// a negedge monitor pops and compares them whenever the PC enable pulses.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        cmp_eq, cmp_lt, cmp_ltu;
    logic        imem_ready, dmem_ready, halt_req;
    logic [3:0]  pc_control;
    logic        imem_req, ir_load, dmem_req, dmem_we, reg_write;
    logic [2:0]  state;
    logic [31:0] instret;
    logic        illegal;

    pc_sequencer #(.RESET_HOLD_CYCLES(2), .INSTRET_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .halt_req(halt_req),
        .pc_control(pc_control), .imem_req(imem_req), .ir_load(ir_load),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
        .state(state), .instret(instret), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  pc;
        logic        rw;
        logic [31:0] ir;
    } wb_t;

    wb_t         sb[$];
    wb_t         mon_e;
    logic [31:0] exp_instret;
    int          checks = 0;
    int          errors = 0;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011,
                           ST = 7'b0100011, OPI = 7'b0010011, OP = 7'b0110011,
                           SYS = 7'b1110011, BAD = 7'b1111111;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every PC enable pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && pc_control[2] === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb_pulse", 32'(pc_control), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_pc_control", 32'(pc_control), 32'(mon_e.pc));
                chk("wb_reg_write", 32'(reg_write), 32'(mon_e.rw));
                chk("wb_instret", instret, mon_e.ir);
            end
        end
    end

    task automatic wait_fetch();
        int n = 0;
        while (state !== 3'd1 && n < 20) begin
            tick();
            n++;
        end
        chk("reach_fetch", 32'(state), 32'd1);
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        halt_req = 1'b0;
        sb.delete();
        exp_instret = 32'd0;
        #1;
        for (int i = 0; i < hold; i++) begin
            chk("rst_pc_control", 32'(pc_control), 32'h8);
            chk("rst_strobes", 32'({imem_req, ir_load, dmem_req, dmem_we, reg_write}), 32'h0);
            chk("rst_state", 32'(state), 32'd0);
            tick();
        end
        reset = 1'b0;
        #1;
        chk("hold1_pc_control", 32'(pc_control), 32'h8);
        tick();
        chk("hold2_pc_control", 32'(pc_control), 32'h8);
        chk("hold2_state", 32'(state), 32'd0);
        tick();
        chk("post_hold_state", 32'(state), 32'd1);
        chk("post_hold_pc_control", 32'(pc_control), 32'h0);
        chk("post_hold_instret", instret, 32'd0);
        chk("post_hold_illegal", 32'(illegal), 32'd0);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic eq, input logic lt, input logic ltu,
                             input int iw, input int dw,
                             input logic [3:0] exp_pc, input logic exp_rw,
                             input logic halt_after);
        logic is_mem;
        is_mem = (op == LD) || (op == ST);
        wait_fetch();
        halt_req = halt_after;
        for (int i = 0; i < iw; i++) begin
            imem_ready = 1'b0;
            #1;
            chk("imem_req_wait", 32'(imem_req), 32'd1);
            chk("ir_load_idle", 32'(ir_load), 32'd0);
            tick();
        end
        imem_ready = 1'b1;
        opcode = op;
        funct3 = f3;
        cmp_eq = eq;
        cmp_lt = lt;
        cmp_ltu = ltu;
        sb.push_back(wb_t'{pc: exp_pc, rw: exp_rw, ir: exp_instret});
        exp_instret = exp_instret + 32'd1;
        #1;
        chk("ir_load_pulse", 32'(ir_load), 32'd1);
        tick();
        imem_ready = 1'b0;
        #1;
        chk("decode_state", 32'(state), 32'd2);
        chk("ir_load_single", 32'(ir_load), 32'd0);
        tick();
        chk("execute_state", 32'(state), 32'd3);
        tick();
        if (is_mem) begin
            for (int i = 0; i < dw; i++) begin
                chk("mem_state", 32'(state), 32'd4);
                chk("dmem_req_wait", 32'(dmem_req), 32'd1);
                chk("dmem_we_wait", 32'(dmem_we), 32'(op == ST));
                tick();
            end
            dmem_ready = 1'b1;
            #1;
            chk("dmem_req_last", 32'(dmem_req), 32'd1);
            chk("dmem_we_last", 32'(dmem_we), 32'(op == ST));
            tick();
            dmem_ready = 1'b0;
        end
        chk("wb_state", 32'(state), 32'd5);
        tick();
        halt_req = 1'b0;
        chk("after_wb_state", 32'(state), halt_after ? 32'd6 : 32'd1);
        chk("after_wb_instret", instret, exp_instret);
    endtask

    task automatic run_halt_op(input logic [6:0] op, input logic exp_ill);
        wait_fetch();
        imem_ready = 1'b1;
        opcode = op;
        tick();
        imem_ready = 1'b0;
        chk("halt_op_decode", 32'(state), 32'd2);
        tick();
        chk("halt_op_state", 32'(state), 32'd6);
        chk("halt_op_illegal", 32'(illegal), 32'(exp_ill));
        for (int i = 0; i < 3; i++) begin
            chk("halt_pc_control", 32'(pc_control), 32'h0);
            chk("halt_strobes", 32'({imem_req, ir_load, dmem_req, dmem_we, reg_write}), 32'h0);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        opcode = 7'd0;
        funct3 = 3'd0;
        {cmp_eq, cmp_lt, cmp_ltu} = 3'b000;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        halt_req = 1'b0;
        exp_instret = 32'd0;
        tick();
        do_reset(3);

        //         op     f3      eq    lt    ltu   iw dw pc       rw    halt
        run_instr(OPI,  3'b000, 1'b0, 1'b0, 1'b0, 2, 0, 4'b0100, 1'b1, 1'b0);
        run_instr(BR,   3'b000, 1'b1, 1'b0, 1'b0, 0, 0, 4'b0110, 1'b0, 1'b0);
        run_instr(BR,   3'b001, 1'b1, 1'b0, 1'b0, 1, 0, 4'b0100, 1'b0, 1'b0);
        run_instr(BR,   3'b111, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0110, 1'b0, 1'b0);
        run_instr(BR,   3'b100, 1'b0, 1'b1, 1'b0, 0, 0, 4'b0110, 1'b0, 1'b0);
        run_instr(BR,   3'b101, 1'b0, 1'b1, 1'b0, 0, 0, 4'b0100, 1'b0, 1'b0);
        run_instr(BR,   3'b010, 1'b1, 1'b1, 1'b1, 0, 0, 4'b0100, 1'b0, 1'b0);
        run_instr(BR,   3'b110, 1'b0, 1'b0, 1'b1, 0, 0, 4'b0110, 1'b0, 1'b0);
        run_instr(JALR, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0101, 1'b1, 1'b0);
        run_instr(JAL,  3'b000, 1'b1, 1'b1, 1'b1, 0, 0, 4'b0110, 1'b1, 1'b0);
        run_instr(ST,   3'b010, 1'b0, 1'b0, 1'b0, 0, 3, 4'b0100, 1'b0, 1'b0);
        run_instr(LD,   3'b010, 1'b0, 1'b0, 1'b0, 1, 1, 4'b0100, 1'b1, 1'b0);
        run_instr(LUI,  3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0100, 1'b1, 1'b0);
        run_instr(AUIPC,3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 4'b0100, 1'b1, 1'b0);
        run_instr(OP,   3'b000, 1'b1, 1'b0, 1'b0, 0, 0, 4'b0100, 1'b1, 1'b0);

        // Reset in the middle of a load's memory phase.
        wait_fetch();
        imem_ready = 1'b1;
        opcode = LD;
        tick();
        imem_ready = 1'b0;
        tick();
        tick();
        chk("midrst_in_memory", 32'(state), 32'd4);
        chk("midrst_dmem_req_before", 32'(dmem_req), 32'd1);
        chk("midrst_instret_before", instret, 32'd15);
        reset = 1'b1;
        #1;
        chk("midrst_pc_control", 32'(pc_control), 32'h8);
        chk("midrst_dmem_req", 32'(dmem_req), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_instret", instret, 32'd0);
        tick();
        do_reset(2);

        // halt_req held high from fetch; only the writeback sample may act on it.
        run_instr(OP, 3'b000, 1'b0, 1'b0, 1'b0, 1, 0, 4'b0100, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("halted_state", 32'(state), 32'd6);
            chk("halted_pc_control", 32'(pc_control), 32'h0);
            chk("halted_instret", instret, 32'd1);
            tick();
        end

        do_reset(2);
        run_halt_op(BAD, 1'b1);
        do_reset(2);
        run_halt_op(SYS, 1'b0);
        chk("system_instret", instret, 32'd0);

        tick();
        tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
